ls_buffer: RTL and testbench
============================

// Module: ls_buffer
// PURPOSE
//  In-order load/store queue; the memory-side counterpart of the reorder buffer's SLB interface.
//  Accepts issued loads/stores and captures operands from the EX broadcast.
//  Executes loads at the head; signals ROB readiness of head stores.
//  Writes stores only after ROB commit; survives flush with committed stores intact.
// PARAMETERS
//  Q_WIDTH   4   ROB tag width; queue depth = 2**Q_WIDTH entries
// PORTS
//  clk_in              in   1        clock, rising edge
//  rst_n_in            in   1        asynchronous active-low reset
//  rdy_in              in   1        0 = freeze all state; outputs hold
//  has_issue           in   1        issue strobe (ignored when full)
//  issue_is_store      in   1        1 = store, 0 = load
//  issue_funct3        in   3        RV32I LB/LH/LW/LBU/LHU/SB/SH/SW encoding
//  issue_Q1,issue_Q2   in   Q_WIDTH  producer ROB tag of base/data; 0 = value valid
//  issue_V1,issue_V2   in   32       base/data value when tag is 0
//  issue_imm           in   32       sign-extended offset
//  issue_rob_pos       in   Q_WIDTH  ROB entry of this instruction
//  has_ex_result       in   1        EX broadcast valid
//  ex_rob_pos          in   Q_WIDTH  EX broadcast tag
//  V_ex                in   32       EX broadcast value
//  has_commit_toSLB    in   1        ROB committing a store this cycle
//  Commit_Q            in   Q_WIDTH  ROB tag of committing store
//  control_hazard      in   1        flush all uncommitted entries
//  mem_req             out  1        memory request, held until mem_done
//  mem_we              out  1        1 = write
//  mem_addr            out  32       V1 + imm
//  mem_size            out  2        0 = byte, 1 = half, 2 = word
//  mem_wdata           out  32       store data, V2 zero-masked to size
//  mem_done            in   1        one-cycle completion pulse
//  mem_rdata           in   32       load data, valid with mem_done
//  has_slb_result      out  1        load result broadcast (one cycle)
//  slb_head_isStore    out  1        head store operands ready (once per store)
//  slb_target_ROB_pos  out  Q_WIDTH  tag for either strobe above
//  V_slb               out  32       load value / store address
//  full                out  1        no free entry
// BEHAVIOUR
//  Reset: queue empty, FSM IDLE; all outputs 0.
//  Issue: entry written at tail next edge.
//  Operand capture: a tag matching ex_rob_pos or slb_target_ROB_pos broadcast captures the value.
//    This includes tags issued in the same cycle (bypass).
//  Simultaneous issue and head retire is allowed at full, but full still blocks issue.
//  Wrap-around: head/tail modulo 2**Q_WIDTH.
//  FSM IDLE:
//    Head load, both tags 0 -> assert mem_req (we = 0), go LOAD_WAIT.
//    Head store, tags 0, not announced -> pulse slb_head_isStore; set announced.
//    Head store, committed -> assert mem_req (we = 1), go STORE_WAIT.
//  LOAD_WAIT, mem_done:
//    Extend rdata per funct3 (LB/LH sign, LBU/LHU zero).
//    Pulse has_slb_result next cycle; pop; go IDLE.
//  STORE_WAIT, mem_done: pop; go IDLE.
//  Commit: has_commit_toSLB sets committed on the entry whose rob_pos == Commit_Q.
//  control_hazard (priority over issue/commit same cycle):
//    tail <= head + number of committed entries (committed form a prefix).
//    In LOAD_WAIT: request stays up until mem_done; result dropped, no broadcast.
//    In STORE_WAIT: unaffected.
//  Misaligned addresses are passed through unchanged.
// CONFIGURATION
//  LSB_STATS_EN defined:
//    Adds outputs load_cnt[31:0] and store_cnt[31:0].
//    Each increments on mem_done of a load/store; reset to 0.
//    Dropped loads are counted.
//  LSB_STATS_EN undefined: ports and counters absent.
// STRUCTURE
//  Shared package: funct3 constants, mem_size encoding, FSM state enum.
//  Sub-module lsb_load_ext: combinational funct3 + rdata -> 32-bit value.
// TESTING
//  LW, Q1 = 0, V1 = 0x100, imm = 4 -> mem_addr 0x104, size 2.
//    rdata 0xDEADBEEF -> V_slb 0xDEADBEEF, tag echoed.
//  LB, rdata 0x80 -> V_slb 0xFFFFFF80.
//    LBU, same rdata -> V_slb 0x00000080.
//  SW, Q2 = 3, then EX broadcast tag 3 value 0x55 -> slb_head_isStore pulses once.
//    No mem_req until has_commit_toSLB with matching Commit_Q.
//    Then write 0x55.
//  Fill 16 entries -> full = 1, 17th issue ignored.
//    Pop one -> full = 0.
//    Tail wraps to entry 0 correctly.
//  Committed SW + 3 loads, control_hazard -> only SW written.
//    Queue then empty, no has_slb_result.
//  Flush during LOAD_WAIT -> mem_req held until mem_done, no broadcast.
//  Assert rst_n_in mid-STORE_WAIT -> mem_req drops asynchronously.

Source files
------------

// File: rtl/ls_buffer_pkg.sv
// Shared definitions for the load/store buffer: funct3 encodings, memory size codes,
// FSM state constants and small encode helpers.
package ls_buffer_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef logic [1:0] mem_size_t;
  localparam mem_size_t SIZE_BYTE = 2'd0;
  localparam mem_size_t SIZE_HALF = 2'd1;
  localparam mem_size_t SIZE_WORD = 2'd2;

  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_LOAD_WAIT  = 2'd1;
  localparam logic [1:0] ST_STORE_WAIT = 2'd2;

  function automatic mem_size_t f3_size(input logic [2:0] f3);
    case (f3)
      F3_LB, F3_LBU: f3_size = SIZE_BYTE;
      F3_LH, F3_LHU: f3_size = SIZE_HALF;
      default:       f3_size = SIZE_WORD;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] v);
    case (f3)
      F3_SB:   store_data = {24'h0, v[7:0]};
      F3_SH:   store_data = {16'h0, v[15:0]};
      default: store_data = v;
    endcase
  endfunction

endpackage

// File: rtl/ls_buffer_if.sv
// Memory-side request/response bus of the load/store buffer.
// master = buffer side, slave = memory side.
interface ls_buffer_if;
  import ls_buffer_pkg::*;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  mem_size_t   mem_size;
  logic [31:0] mem_wdata;
  logic        mem_done;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_size, mem_wdata,
    input  mem_done, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_size, mem_wdata,
    output mem_done, mem_rdata
  );
endinterface

// File: rtl/lsb_load_ext.sv
// Load data extension: selects byte/half/word from rdata and sign- or zero-extends
// according to the load funct3.
module lsb_load_ext
  import ls_buffer_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] rdata,
  output logic [31:0] value
);

  always_comb begin
    case (funct3)
      F3_LB:   value = {{24{rdata[7]}}, rdata[7:0]};
      F3_LH:   value = {{16{rdata[15]}}, rdata[15:0]};
      F3_LBU:  value = {24'h0, rdata[7:0]};
      F3_LHU:  value = {16'h0, rdata[15:0]};
      default: value = rdata;
    endcase
  end

endmodule

// File: rtl/ls_buffer.sv
// In-order load/store queue: captures operands from EX/SLB broadcasts, runs loads at the
// head, announces ready head stores and writes them after commit. Optional LSB_STATS_EN.
module ls_buffer
  import ls_buffer_pkg::*;
#(
  parameter int Q_WIDTH = 4
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  input  logic               rdy_in,
  input  logic               has_issue,
  input  logic               issue_is_store,
  input  logic [2:0]         issue_funct3,
  input  logic [Q_WIDTH-1:0] issue_Q1,
  input  logic [Q_WIDTH-1:0] issue_Q2,
  input  logic [31:0]        issue_V1,
  input  logic [31:0]        issue_V2,
  input  logic [31:0]        issue_imm,
  input  logic [Q_WIDTH-1:0] issue_rob_pos,
  input  logic               has_ex_result,
  input  logic [Q_WIDTH-1:0] ex_rob_pos,
  input  logic [31:0]        V_ex,
  input  logic               has_commit_toSLB,
  input  logic [Q_WIDTH-1:0] Commit_Q,
  input  logic               control_hazard,
  ls_buffer_if.master        mem,
  output logic               has_slb_result,
  output logic               slb_head_isStore,
  output logic [Q_WIDTH-1:0] slb_target_ROB_pos,
  output logic [31:0]        V_slb,
  output logic               full
`ifdef LSB_STATS_EN
  ,
  output logic [31:0]        load_cnt,
  output logic [31:0]        store_cnt
`endif
);

  localparam int DEPTH = 1 << Q_WIDTH;

  typedef logic [Q_WIDTH-1:0] tag_t;
  typedef logic [Q_WIDTH:0]   cnt_t;

  typedef struct packed {
    logic        is_store;
    logic [2:0]  funct3;
    tag_t        q1;
    tag_t        q2;
    logic [31:0] v1;
    logic [31:0] v2;
    logic [31:0] imm;
    tag_t        rob_pos;
    logic        committed;
    logic        announced;
  } entry_t;

  typedef struct packed {
    tag_t        q;
    logic [31:0] v;
  } opnd_t;

  // Resolve a pending operand against this cycle's EX and SLB broadcasts.
  function automatic opnd_t capture(input tag_t q, input logic [31:0] v,
                                    input logic ex_vld, input tag_t ex_tag, input logic [31:0] ex_val,
                                    input logic sl_vld, input tag_t sl_tag, input logic [31:0] sl_val);
    opnd_t r;
    r.q = q;
    r.v = v;
    if (q != '0) begin
      if (ex_vld && ex_tag == q) begin
        r.q = '0;
        r.v = ex_val;
      end else if (sl_vld && sl_tag == q) begin
        r.q = '0;
        r.v = sl_val;
      end
    end
    return r;
  endfunction

  logic [1:0]  state_q, state_d;
  tag_t        head_q, head_d;
  cnt_t        count_q, count_d;
  logic        drop_q, drop_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  mem_size_t   mem_size_q, mem_size_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        has_slb_result_q, has_slb_result_d;
  logic        slb_head_isStore_q, slb_head_isStore_d;
  tag_t        slb_target_q, slb_target_d;
  logic [31:0] v_slb_q, v_slb_d;

  entry_t           ent_all [DEPTH];
  logic [DEPTH-1:0] valid_vec;
  entry_t           head_ent;
  entry_t           issue_ent;
  opnd_t            iss_o1, iss_o2;
  tag_t             tail;
  cnt_t             committed_cnt;
  logic             push, pop, announce_head, commit_en, flush;
  logic [31:0]      head_addr, load_val;
  logic             head_valid, head_ready;

  assign flush      = control_hazard;
  assign tail       = head_q + count_q[Q_WIDTH-1:0];
  assign push       = has_issue && !count_q[Q_WIDTH] && !flush;
  assign commit_en  = has_commit_toSLB && !flush;
  assign head_ent   = ent_all[head_q];
  assign head_addr  = head_ent.v1 + head_ent.imm;
  assign head_valid = (count_q != '0);
  assign head_ready = (head_ent.q1 == '0) && (head_ent.q2 == '0);

  always_comb begin
    iss_o1 = capture(issue_Q1, issue_V1, has_ex_result, ex_rob_pos, V_ex,
                     has_slb_result_q, slb_target_q, v_slb_q);
    iss_o2 = capture(issue_Q2, issue_V2, has_ex_result, ex_rob_pos, V_ex,
                     has_slb_result_q, slb_target_q, v_slb_q);
    issue_ent           = '0;
    issue_ent.is_store  = issue_is_store;
    issue_ent.funct3    = issue_funct3;
    issue_ent.q1        = iss_o1.q;
    issue_ent.v1        = iss_o1.v;
    issue_ent.q2        = iss_o2.q;
    issue_ent.v2        = iss_o2.v;
    issue_ent.imm       = issue_imm;
    issue_ent.rob_pos   = issue_rob_pos;
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_ent
      entry_t ent_q, ent_d;
      opnd_t  o1, o2;

      // Entry is live when its distance from head is below the occupancy.
      assign valid_vec[gi] = ({1'b0, tag_t'(gi) - head_q} < count_q);

      always_comb begin
        ent_d = ent_q;
        o1 = capture(ent_q.q1, ent_q.v1, has_ex_result, ex_rob_pos, V_ex,
                     has_slb_result_q, slb_target_q, v_slb_q);
        o2 = capture(ent_q.q2, ent_q.v2, has_ex_result, ex_rob_pos, V_ex,
                     has_slb_result_q, slb_target_q, v_slb_q);
        if (valid_vec[gi]) begin
          ent_d.q1 = o1.q;
          ent_d.v1 = o1.v;
          ent_d.q2 = o2.q;
          ent_d.v2 = o2.v;
          if (commit_en && ent_q.is_store && ent_q.rob_pos == Commit_Q)
            ent_d.committed = 1'b1;
          if (announce_head && head_q == tag_t'(gi))
            ent_d.announced = 1'b1;
        end
        if (push && tail == tag_t'(gi))
          ent_d = issue_ent;
      end

      always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in)   ent_q <= '0;
        else if (rdy_in) ent_q <= ent_d;
      end

      assign ent_all[gi] = ent_q;
    end
  endgenerate

  // Committed entries form a prefix from head, so a flush keeps exactly this many.
  always_comb begin
    committed_cnt = '0;
    for (int i = 0; i < DEPTH; i++)
      if (valid_vec[i] && ent_all[i].committed)
        committed_cnt = committed_cnt + cnt_t'(1);
  end

  lsb_load_ext u_load_ext (
    .funct3 (head_ent.funct3),
    .rdata  (mem.mem_rdata),
    .value  (load_val)
  );

  always_comb begin
    state_d            = state_q;
    drop_d             = drop_q;
    mem_req_d          = mem_req_q;
    mem_we_d           = mem_we_q;
    mem_addr_d         = mem_addr_q;
    mem_size_d         = mem_size_q;
    mem_wdata_d        = mem_wdata_q;
    has_slb_result_d   = 1'b0;
    slb_head_isStore_d = 1'b0;
    slb_target_d       = slb_target_q;
    v_slb_d            = v_slb_q;
    pop                = 1'b0;
    announce_head      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (head_valid && head_ready) begin
          if (!head_ent.is_store) begin
            if (!flush) begin
              mem_req_d  = 1'b1;
              mem_we_d   = 1'b0;
              mem_addr_d = head_addr;
              mem_size_d = f3_size(head_ent.funct3);
              drop_d     = 1'b0;
              state_d    = ST_LOAD_WAIT;
            end
          end else if (head_ent.committed) begin
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b1;
            mem_addr_d  = head_addr;
            mem_size_d  = f3_size(head_ent.funct3);
            mem_wdata_d = store_data(head_ent.funct3, head_ent.v2);
            state_d     = ST_STORE_WAIT;
          end else if (!head_ent.announced && !flush) begin
            slb_head_isStore_d = 1'b1;
            slb_target_d       = head_ent.rob_pos;
            v_slb_d            = head_addr;
            announce_head      = 1'b1;
          end
        end
      end
      ST_LOAD_WAIT: begin
        // A flushed load already left the queue; its response is absorbed silently.
        if (flush) drop_d = 1'b1;
        if (mem.mem_done) begin
          mem_req_d = 1'b0;
          state_d   = ST_IDLE;
          drop_d    = 1'b0;
          if (!drop_q && !flush) begin
            has_slb_result_d = 1'b1;
            slb_target_d     = head_ent.rob_pos;
            v_slb_d          = load_val;
            pop              = 1'b1;
          end
        end
      end
      ST_STORE_WAIT: begin
        if (mem.mem_done) begin
          mem_req_d = 1'b0;
          state_d   = ST_IDLE;
          pop       = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    head_d = head_q + tag_t'(pop);
    if (flush) count_d = committed_cnt - cnt_t'(pop);
    else       count_d = count_q + cnt_t'(push) - cnt_t'(pop);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q            <= ST_IDLE;
      head_q             <= '0;
      count_q            <= '0;
      drop_q             <= 1'b0;
      mem_req_q          <= 1'b0;
      mem_we_q           <= 1'b0;
      mem_addr_q         <= '0;
      mem_size_q         <= '0;
      mem_wdata_q        <= '0;
      has_slb_result_q   <= 1'b0;
      slb_head_isStore_q <= 1'b0;
      slb_target_q       <= '0;
      v_slb_q            <= '0;
    end else if (rdy_in) begin
      state_q            <= state_d;
      head_q             <= head_d;
      count_q            <= count_d;
      drop_q             <= drop_d;
      mem_req_q          <= mem_req_d;
      mem_we_q           <= mem_we_d;
      mem_addr_q         <= mem_addr_d;
      mem_size_q         <= mem_size_d;
      mem_wdata_q        <= mem_wdata_d;
      has_slb_result_q   <= has_slb_result_d;
      slb_head_isStore_q <= slb_head_isStore_d;
      slb_target_q       <= slb_target_d;
      v_slb_q            <= v_slb_d;
    end
  end

  assign mem.mem_req         = mem_req_q;
  assign mem.mem_we          = mem_we_q;
  assign mem.mem_addr        = mem_addr_q;
  assign mem.mem_size        = mem_size_q;
  assign mem.mem_wdata       = mem_wdata_q;
  assign has_slb_result      = has_slb_result_q;
  assign slb_head_isStore    = slb_head_isStore_q;
  assign slb_target_ROB_pos  = slb_target_q;
  assign V_slb               = v_slb_q;
  assign full                = count_q[Q_WIDTH];

`ifdef LSB_STATS_EN
  logic [31:0] load_cnt_q, load_cnt_d, store_cnt_q, store_cnt_d;

  // Dropped loads still consumed a memory access, so they are counted too.
  always_comb begin
    load_cnt_d  = load_cnt_q;
    store_cnt_d = store_cnt_q;
    if (mem.mem_done && state_q == ST_LOAD_WAIT)  load_cnt_d  = load_cnt_q + 32'd1;
    if (mem.mem_done && state_q == ST_STORE_WAIT) store_cnt_d = store_cnt_q + 32'd1;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      load_cnt_q  <= '0;
      store_cnt_q <= '0;
    end else if (rdy_in) begin
      load_cnt_q  <= load_cnt_d;
      store_cnt_q <= store_cnt_d;
    end
  end

  assign load_cnt  = load_cnt_q;
  assign store_cnt = store_cnt_q;
`endif

endmodule

// File: tb/tb_ls_buffer.sv
// Directed bench for ls_buffer: loads with extension, store announce/commit, full/wrap,
// flush with committed prefix, flush during a pending load, freeze and async reset.
module tb_ls_buffer;

  logic        clk = 1'b0;
  logic        rst_n, rdy;
  logic        has_issue, issue_is_store;
  logic [2:0]  issue_funct3;
  logic [3:0]  issue_Q1, issue_Q2, issue_rob_pos;
  logic [31:0] issue_V1, issue_V2, issue_imm;
  logic        has_ex_result;
  logic [3:0]  ex_rob_pos;
  logic [31:0] V_ex;
  logic        has_commit;
  logic [3:0]  Commit_Q;
  logic        control_hazard;
  logic        has_slb_result, slb_head_isStore, full;
  logic [3:0]  slb_target;
  logic [31:0] V_slb;
`ifdef LSB_STATS_EN
  logic [31:0] load_cnt, store_cnt;
`endif

  int checks = 0;
  int failures = 0;

  ls_buffer_if bus ();

  ls_buffer #(.Q_WIDTH(4)) dut (
`ifdef LSB_STATS_EN
    .load_cnt           (load_cnt),
    .store_cnt          (store_cnt),
`endif
    .clk_in             (clk),
    .rst_n_in           (rst_n),
    .rdy_in             (rdy),
    .has_issue          (has_issue),
    .issue_is_store     (issue_is_store),
    .issue_funct3       (issue_funct3),
    .issue_Q1           (issue_Q1),
    .issue_Q2           (issue_Q2),
    .issue_V1           (issue_V1),
    .issue_V2           (issue_V2),
    .issue_imm          (issue_imm),
    .issue_rob_pos      (issue_rob_pos),
    .has_ex_result      (has_ex_result),
    .ex_rob_pos         (ex_rob_pos),
    .V_ex               (V_ex),
    .has_commit_toSLB   (has_commit),
    .Commit_Q           (Commit_Q),
    .control_hazard     (control_hazard),
    .mem                (bus),
    .has_slb_result     (has_slb_result),
    .slb_head_isStore   (slb_head_isStore),
    .slb_target_ROB_pos (slb_target),
    .V_slb              (V_slb),
    .full               (full)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic st, input logic [2:0] f3, input logic [3:0] q1, input logic [31:0] v1,
                       input logic [3:0] q2, input logic [31:0] v2, input logic [31:0] imm,
                       input logic [3:0] rob);
    has_issue = 1'b1; issue_is_store = st; issue_funct3 = f3;
    issue_Q1 = q1; issue_V1 = v1; issue_Q2 = q2; issue_V2 = v2;
    issue_imm = imm; issue_rob_pos = rob;
    tick();
    has_issue = 1'b0;
  endtask

  task automatic ex_bcast(input logic [3:0] tag, input logic [31:0] val);
    has_ex_result = 1'b1; ex_rob_pos = tag; V_ex = val;
    tick();
    has_ex_result = 1'b0;
  endtask

  task automatic commit(input logic [3:0] tag);
    has_commit = 1'b1; Commit_Q = tag;
    tick();
    has_commit = 1'b0;
  endtask

  task automatic hazard();
    control_hazard = 1'b1;
    tick();
    control_hazard = 1'b0;
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (!bus.mem_req && n < 20) begin tick(); n++; end
    check({tag, "_req"}, {31'd0, bus.mem_req}, 32'd1);
  endtask

  task automatic wait_announce(input string tag);
    int n = 0;
    while (!slb_head_isStore && n < 20) begin tick(); n++; end
    check({tag, "_ann"}, {31'd0, slb_head_isStore}, 32'd1);
  endtask

  task automatic complete(input logic [31:0] rdata);
    bus.mem_done = 1'b1; bus.mem_rdata = rdata;
    tick();
    bus.mem_done = 1'b0; bus.mem_rdata = '0;
  endtask

  task automatic run_load(input string tag, input logic [3:0] rob, input logic [2:0] f3,
                          input logic [31:0] v1, input logic [31:0] imm, input logic [31:0] rdata,
                          input logic [31:0] exp_addr, input logic [1:0] exp_size, input logic [31:0] exp_val);
    issue(1'b0, f3, 4'd0, v1, 4'd0, 32'd0, imm, rob);
    wait_req(tag);
    check({tag, "_we"},   {31'd0, bus.mem_we}, 32'd0);
    check({tag, "_addr"}, bus.mem_addr, exp_addr);
    check({tag, "_size"}, {30'd0, bus.mem_size}, {30'd0, exp_size});
    complete(rdata);
    check({tag, "_res"},  {31'd0, has_slb_result}, 32'd1);
    check({tag, "_val"},  V_slb, exp_val);
    check({tag, "_tag"},  {28'd0, slb_target}, {28'd0, rob});
    tick();
    check({tag, "_pulse"}, {31'd0, has_slb_result}, 32'd0);
  endtask

  task automatic drain_store(input string tag, input logic [3:0] rob, input logic [31:0] exp_addr,
                             input logic [31:0] exp_data, input logic [1:0] exp_size);
    wait_announce(tag);
    check({tag, "_anntag"},  {28'd0, slb_target}, {28'd0, rob});
    check({tag, "_annaddr"}, V_slb, exp_addr);
    commit(rob);
    wait_req(tag);
    check({tag, "_we"},    {31'd0, bus.mem_we}, 32'd1);
    check({tag, "_addr"},  bus.mem_addr, exp_addr);
    check({tag, "_wdata"}, bus.mem_wdata, exp_data);
    check({tag, "_size"},  {30'd0, bus.mem_size}, {30'd0, exp_size});
    complete(32'd0);
    check({tag, "_reqdrop"}, {31'd0, bus.mem_req}, 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ann, req, res, tgt, addr;
    rst_n = 1'b0; rdy = 1'b1;
    has_issue = 0; issue_is_store = 0; issue_funct3 = 0;
    issue_Q1 = 0; issue_Q2 = 0; issue_V1 = 0; issue_V2 = 0; issue_imm = 0; issue_rob_pos = 0;
    has_ex_result = 0; ex_rob_pos = 0; V_ex = 0;
    has_commit = 0; Commit_Q = 0; control_hazard = 0;
    bus.mem_done = 1'b0; bus.mem_rdata = '0;
    tick(); tick();

    check("rst_req",  {31'd0, bus.mem_req}, 32'd0);
    check("rst_res",  {31'd0, has_slb_result}, 32'd0);
    check("rst_ann",  {31'd0, slb_head_isStore}, 32'd0);
    check("rst_tag",  {28'd0, slb_target}, 32'd0);
    check("rst_vslb", V_slb, 32'd0);
    check("rst_full", {31'd0, full}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Loads: word, then byte/half with sign and zero extension; negative offset.
    run_load("lw",  4'd1, 3'b010, 32'h100, 32'd4,        32'hDEADBEEF, 32'h104, 2'd2, 32'hDEADBEEF);
    run_load("lb",  4'd2, 3'b000, 32'h200, 32'hFFFFFFFC, 32'h00000080, 32'h1FC, 2'd0, 32'hFFFFFF80);
    run_load("lbu", 4'd3, 3'b100, 32'h200, 32'hFFFFFFFC, 32'h00000080, 32'h1FC, 2'd0, 32'h00000080);
    run_load("lh",  4'd4, 3'b001, 32'h210, 32'd2,        32'h00018000, 32'h212, 2'd1, 32'hFFFF8000);
    run_load("lhu", 4'd5, 3'b101, 32'h210, 32'd2,        32'h00018000, 32'h212, 2'd1, 32'h00008000);

    // Store waiting on a data tag: no announce until EX broadcast, no write until commit.
    issue(1'b1, 3'b010, 4'd0, 32'h300, 4'd3, 32'd0, 32'd8, 4'd5);
    ann = 0; req = 0;
    repeat (6) begin tick(); ann += slb_head_isStore; req += bus.mem_req; end
    check("sw_noann", ann, 0);
    check("sw_noreq0", req, 0);
    ex_bcast(4'd3, 32'h55);
    ann = 0; req = 0; tgt = 0; addr = 0;
    repeat (6) begin
      tick();
      if (slb_head_isStore) begin ann++; tgt = slb_target; addr = V_slb; end
      req += bus.mem_req;
    end
    check("sw_ann_once", ann, 1);
    check("sw_anntag", tgt, 5);
    check("sw_annaddr", addr, 32'h308);
    check("sw_noreq1", req, 0);
    commit(4'd5);
    wait_req("sw");
    check("sw_we",    {31'd0, bus.mem_we}, 32'd1);
    check("sw_addr",  bus.mem_addr, 32'h308);
    check("sw_wdata", bus.mem_wdata, 32'h55);
    check("sw_size",  {30'd0, bus.mem_size}, 32'd2);
    complete(32'd0);
    check("sw_reqdrop", {31'd0, bus.mem_req}, 32'd0);

    // Fill to full (tail wraps past entry 15), 17th issue ignored.
    for (int i = 0; i < 16; i++) begin
      check("fill_notfull", {31'd0, full}, 32'd0);
      issue(1'b1, 3'b010, 4'd0, 32'h1000 + 32'(i) * 4, 4'd1, 32'd0, 32'd0, 4'(i));
    end
    check("fill_full", {31'd0, full}, 32'd1);
    issue(1'b1, 3'b010, 4'd0, 32'hBAD0, 4'd0, 32'h66, 32'd0, 4'd3);
    check("fill_full17", {31'd0, full}, 32'd1);
    ex_bcast(4'd1, 32'hA0);
    drain_store("d0", 4'd0, 32'h1000, 32'hA0, 2'd2);
    check("pop_notfull", {31'd0, full}, 32'd0);
    issue(1'b1, 3'b010, 4'd0, 32'h2000, 4'd0, 32'h77, 32'd0, 4'd0);
    check("refill_full", {31'd0, full}, 32'd1);
    for (int i = 1; i < 16; i++)
      drain_store($sformatf("d%0d", i), 4'(i), 32'h1000 + 32'(i) * 4, 32'hA0, 2'd2);
    drain_store("dnew", 4'd0, 32'h2000, 32'h77, 2'd2);
    ann = 0; req = 0;
    repeat (6) begin tick(); ann += slb_head_isStore; req += bus.mem_req; end
    check("drained_noann", ann, 0);
    check("drained_noreq", req, 0);

    // Committed misaligned SH followed by three loads, then flush: only the store survives.
    issue(1'b1, 3'b001, 4'd0, 32'h400, 4'd0, 32'h12345699, 32'd1, 4'd2);
    wait_announce("fl");
    check("fl_anntag", {28'd0, slb_target}, 32'd2);
    check("fl_annaddr", V_slb, 32'h401);
    issue(1'b0, 3'b010, 4'd0, 32'h600, 4'd0, 32'd0, 32'd0, 4'd3);
    issue(1'b0, 3'b010, 4'd0, 32'h604, 4'd0, 32'd0, 32'd0, 4'd4);
    issue(1'b0, 3'b010, 4'd0, 32'h608, 4'd0, 32'd0, 32'd0, 4'd5);
    commit(4'd2);
    hazard();
    wait_req("fl");
    check("fl_we",    {31'd0, bus.mem_we}, 32'd1);
    check("fl_addr",  bus.mem_addr, 32'h401);
    check("fl_wdata", bus.mem_wdata, 32'h5699);
    check("fl_size",  {30'd0, bus.mem_size}, 32'd1);
    complete(32'd0);
    req = 0; res = 0;
    repeat (8) begin tick(); req += bus.mem_req; res += has_slb_result; end
    check("fl_noreq", req, 0);
    check("fl_nores", res, 0);
    run_load("postfl", 4'd6, 3'b010, 32'h700, 32'd0, 32'h13572468, 32'h700, 2'd2, 32'h13572468);

    // Flush while a load is outstanding: request held, response dropped.
    issue(1'b0, 3'b010, 4'd0, 32'h500, 4'd0, 32'd0, 32'd0, 4'd7);
    wait_req("lwfl");
    hazard();
    req = 0;
    repeat (3) begin tick(); req += bus.mem_req; end
    check("lwfl_held", req, 3);
    complete(32'h1234);
    check("lwfl_nores", {31'd0, has_slb_result}, 32'd0);
    check("lwfl_reqdrop", {31'd0, bus.mem_req}, 32'd0);
    tick();
    check("lwfl_nores2", {31'd0, has_slb_result}, 32'd0);
    check("lwfl_idle", {31'd0, bus.mem_req}, 32'd0);

    // Freeze: with rdy low a ready head load does not start.
    issue(1'b0, 3'b010, 4'd0, 32'h800, 4'd0, 32'd0, 32'd0, 4'd8);
    rdy = 1'b0;
    req = 0;
    repeat (3) begin tick(); req += bus.mem_req; end
    check("frz_noreq", req, 0);
    rdy = 1'b1;
    wait_req("frz");
    check("frz_addr", bus.mem_addr, 32'h800);
    complete(32'hCAFEF00D);
    check("frz_res", {31'd0, has_slb_result}, 32'd1);
    check("frz_val", V_slb, 32'hCAFEF00D);
    check("frz_tag", {28'd0, slb_target}, 32'd8);
    tick();

    // Asynchronous reset in the middle of STORE_WAIT.
    issue(1'b1, 3'b010, 4'd0, 32'h900, 4'd0, 32'h11, 32'd0, 4'd9);
    wait_announce("ar");
    commit(4'd9);
    wait_req("ar");
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_reqdrop", {31'd0, bus.mem_req}, 32'd0);
    check("ar_full", {31'd0, full}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("ar_req_after", {31'd0, bus.mem_req}, 32'd0);
    check("ar_ann_after", {31'd0, slb_head_isStore}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
